fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param.sv | 127 ++++++++++++
 tb/tb_fifo_param.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Purpose : single-clock parametric FIFO with occupancy count, almost flags and over/underflow pulses.
// Latency : write-to-empty deassert 1 cycle; read data 1 cycle after accepted read (FWFT: head word shown directly).
// Backpres: writes refused while full, reads refused while empty; refused requests raise a one-cycle flag.
//
// Ports:
//   clk, rst           - clock, synchronous active-low reset
//   wr_en, wr_data     - write request and word
//   rd_en, rd_data     - read request and word
//   full, empty        - count==DEPTH, count==0
//   almost_full/empty  - count>=AF_LEVEL, count<=AE_LEVEL
//   count              - occupancy 0..DEPTH
//   overflow/underflow - one-cycle pulse after a rejected write/read
//
// Build option: define FIFO_FWFT_EN for first-word-fall-through read data.
module fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_acc, rd_acc;

    // Status flags come only from the registered count, so a same-cycle
    // read never frees room for a write when full (and vice versa).
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        wr_acc      = wr_en && !full;
        rd_acc      = rd_en && !empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = wr_en && full;
        underflow_d = rd_en && empty;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Simultaneous accepted read and write leave occupancy unchanged.
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst && wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is visible without a read; content is meaningless while empty.
    assign rd_data = mem[rd_ptr_q];
`else
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_acc) begin
            rd_data_d = mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          full, empty, almost_full, almost_empty;
    logic [4:0]    count;
    logic          overflow, underflow;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: contents as a plain queue, plus last delivered word.
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_rd;
    logic          exp_ov, exp_un;

    always #5 clk = ~clk;

    fifo_param #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
    task automatic step(input logic rst_v, input logic w, input logic [DW-1:0] wd, input logic r);
        bit was_full, was_empty;
        rst     = rst_v;
        wr_en   = w;
        wr_data = wd;
        rd_en   = r;
        @(posedge clk);
        if (!rst_v) begin
            q.delete();
            exp_rd = '0;
            exp_ov = 1'b0;
            exp_un = 1'b0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            exp_ov = w && was_full;
            exp_un = r && was_empty;
            if (r && !was_empty) exp_rd = q.pop_front();
            if (w && !was_full) q.push_back(wd);
        end
        @(negedge clk);
        check("count",        32'(count),        32'(q.size()));
        check("full",         32'(full),         32'(q.size() == DEPTH));
        check("empty",        32'(empty),        32'(q.size() == 0));
        check("almost_full",  32'(almost_full),  32'(q.size() >= AF));
        check("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
        check("overflow",     32'(overflow),     32'(exp_ov));
        check("underflow",    32'(underflow),    32'(exp_un));
`ifdef FIFO_FWFT_EN
        if (q.size() != 0) check("rd_data", 32'(rd_data), 32'(q[0]));
`else
        check("rd_data", 32'(rd_data), 32'(exp_rd));
`endif
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
        exp_rd = '0; exp_ov = 1'b0; exp_un = 1'b0;
        @(negedge clk);

        // Reset state
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Fill with 0x01..0x10, then attempt overflow with 0xFF
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b1, 8'(i), 1'b0);
        step(1'b1, 1'b1, 8'hFF, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Drain in order, then one read past empty
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Hold at 8 with simultaneous read/write across several wraps
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'(8'h28 + i), 1'b1);

        // Reset mid-operation at count 5 with a write pending
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(8'h60 + i), 1'b0);
        step(1'b0, 1'b1, 8'h77, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Single word, then read it back
        step(1'b1, 1'b1, 8'hA5, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Randomized traffic with phases biased toward full and toward empty
        for (int i = 0; i < 1500; i++) begin
            int wp;
            logic w, r, rs;
            wp = ((i / 150) % 2 == 0) ? 75 : 30;
            w  = ($urandom_range(99) < wp);
            r  = ($urandom_range(99) < (100 - wp));
            rs = ($urandom_range(299) != 0);
            step(rs, w, 8'($urandom), r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
